// File: rtl/adc_pkg.sv
// Shared ADC definitions: channel word width, default timing and the
// sequencer FSM encoding. Also imported by the SPI ADC reader.
package adc_pkg;

    localparam int ADC_DATA_W  = 14;
    localparam int ADC_PERIOD  = 100;
    localparam int ADC_TIMEOUT = 64;

    // Sequencer FSM encoding (kept as plain constants for legacy users)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_ACCUM = 2'd3;

    // Single-cycle rising-edge detect against one registered copy
    function automatic logic rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Two-channel signed boxcar accumulator. Adds one sign-extended sample pair
// per 'add' pulse and, on the 2^AVG_LOG2-th sample, presents the floored
// mean combinationally with 'done' while clearing its state.
module adc_avg_accum
    import adc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [DATA_W-1:0] ch0,
    input  logic [DATA_W-1:0] ch1,
    output logic              done,
    output logic [DATA_W-1:0] avg0,
    output logic [DATA_W-1:0] avg1
);

    // Sum of 2^AVG_LOG2 DATA_W-bit words always fits in DATA_W+AVG_LOG2 bits
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);

    logic signed [ACC_W-1:0] acc0_r, acc1_r;
    logic signed [ACC_W-1:0] ext0_s, ext1_s, sum0_s, sum1_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;

    // Running sums including the current sample and the averaged result
    always_comb begin
        ext0_s    = ACC_W'($signed(ch0));
        ext1_s    = ACC_W'($signed(ch1));
        sum0_s    = acc0_r + ext0_s;
        sum1_s    = acc1_r + ext1_s;
        cnt_nxt_s = cnt_r + CNT_W'(1);
        done      = add && (cnt_nxt_s == CNT_FULL);
        avg0      = DATA_W'(sum0_s >>> AVG_LOG2);
        avg1      = DATA_W'(sum1_s >>> AVG_LOG2);
    end

    // Accumulator and sample counter; cleared on abort or on block completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc0_r <= '0;
            acc1_r <= '0;
            cnt_r  <= '0;
        end else if (clear || done) begin
            acc0_r <= '0;
            acc1_r <= '0;
            cnt_r  <= '0;
        end else if (add) begin
            acc0_r <= sum0_s;
            acc1_r <= sum1_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC sample sequencer: triggers conversions at a fixed rate, captures the
// channel pair on end-of-conversion, averages 2^AVG_LOG2 samples and offers
// the result on a valid/ready stream with sticky overrun/timeout flags.
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int DATA_W   = ADC_DATA_W,
    parameter int PERIOD   = ADC_PERIOD,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = ADC_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              conv,
    input  logic              end_conv,
    input  logic [DATA_W-1:0] ch0_in,
    input  logic [DATA_W-1:0] ch1_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ch0,
    output logic [DATA_W-1:0] out_ch1,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              clear_flags
);

    localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [1:0]        state_r, state_nxt_s;
    logic [PER_W-1:0]  per_cnt_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              end_conv_d_r;
    logic [DATA_W-1:0] cap0_r, cap1_r;

    logic              end_edge_s, trig_s, tmo_hit_s, acc_add_s;
    logic              res_done_s, ovr_set_s;
    logic [DATA_W-1:0] avg0_s, avg1_s;

    // Decode trigger, end-of-conversion edge and timeout events
    always_comb begin
        end_edge_s = rising(end_conv, end_conv_d_r);
        trig_s     = (state_r == ST_WAIT) && enable && (per_cnt_r == PER_W'(0));
        tmo_hit_s  = (state_r == ST_BUSY) && !end_edge_s &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
        acc_add_s  = (state_r == ST_ACCUM);
        ovr_set_s  = res_done_s && out_valid && !out_ready;
    end

    // Next-state logic; a period wrap during BUSY is simply not acted upon
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_WAIT;
                else        state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (!enable)     state_nxt_s = ST_IDLE;
                else if (trig_s) state_nxt_s = ST_BUSY;
                else             state_nxt_s = ST_WAIT;
            end
            ST_BUSY: begin
                if (end_edge_s)     state_nxt_s = ST_ACCUM;
                else if (tmo_hit_s) state_nxt_s = enable ? ST_WAIT : ST_IDLE;
                else                state_nxt_s = ST_BUSY;
            end
            ST_ACCUM: begin
                state_nxt_s = enable ? ST_WAIT : ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Free-running trigger period counter, parked at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  per_cnt_r <= '0;
        else if (!enable)                           per_cnt_r <= '0;
        else if (per_cnt_r == PER_W'(PERIOD - 1))   per_cnt_r <= '0;
        else                                        per_cnt_r <= per_cnt_r + PER_W'(1);
    end

    // FSM state, one-clock conv pulse and clocks-since-conv counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            conv      <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            conv      <= trig_s;
            tmo_cnt_r <= (state_r == ST_BUSY) ? tmo_cnt_r + TMO_W'(1) : TMO_W'(0);
        end
    end

    // Edge-detect copy of end_conv and channel capture on an accepted edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            end_conv_d_r <= 1'b0;
            cap0_r       <= '0;
            cap1_r       <= '0;
        end else begin
            end_conv_d_r <= end_conv;
            if ((state_r == ST_BUSY) && end_edge_s) begin
                cap0_r <= ch0_in;
                cap1_r <= ch1_in;
            end
        end
    end

    adc_avg_accum #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (tmo_hit_s),
        .add   (acc_add_s),
        .ch0   (cap0_r),
        .ch1   (cap1_r),
        .done  (res_done_s),
        .avg0  (avg0_s),
        .avg1  (avg1_s)
    );

    // Output holding register: load when empty or draining, else drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch0   <= '0;
            out_ch1   <= '0;
        end else if (res_done_s) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_ch0   <= avg0_s;
                out_ch1   <= avg1_s;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a same-cycle set beats clear_flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (ovr_set_s)        overrun <= 1'b1;
            else if (clear_flags) overrun <= 1'b0;
            if (tmo_hit_s)        timeout_err <= 1'b1;
            else if (clear_flags) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: an averaging instance (AVG_LOG2=2) and a
// pass-through instance (AVG_LOG2=0) share one ADC responder model. Expected
// pairs are queued when samples are delivered and popped on handshakes.
module tb_adc_sample_sequencer;

    localparam int DW = 14;

    logic clk = 1'b0;
    logic reset, enable, end_conv, out_ready, clear_flags;
    logic [DW-1:0] ch0_in, ch1_in;

    logic conv, out_valid, overrun, timeout_err;
    logic [DW-1:0] out_ch0, out_ch1;
    logic conv0, out_valid0, overrun0, timeout_err0;
    logic [DW-1:0] out0_ch0, out0_ch1;
    logic ready0;

    int checks = 0;
    int errors = 0;

    int samp0[$], samp1[$];
    int q2a[$], q2b[$], q0a[$], q0b[$];
    int sum0, sum1, scnt, mode, n_samp, conv_count, rec, cyc;
    int m, dly, c0, c1, r0, r1;
    bit suppress;

    adc_sample_sequencer #(.AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .conv(conv),
        .end_conv(end_conv), .ch0_in(ch0_in), .ch1_in(ch1_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ch0(out_ch0), .out_ch1(out_ch1), .overrun(overrun),
        .timeout_err(timeout_err), .clear_flags(clear_flags)
    );

    adc_sample_sequencer #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .conv(conv0),
        .end_conv(end_conv), .ch0_in(ch0_in), .ch1_in(ch1_in),
        .out_valid(out_valid0), .out_ready(ready0),
        .out_ch0(out0_ch0), .out_ch1(out0_ch1), .overrun(overrun0),
        .timeout_err(timeout_err0), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next conv pulse; cyc = clocks waited
    task automatic wait_conv();
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1);
            cyc++;
            if (conv) seen = 1'b1;
        end
        if (!seen) chk("conv_wait_expired", 0, 1);
    endtask

    task automatic wait_samples(input int k);
        for (int i = 0; i < 3000 && n_samp < k; i++) step(1);
        if (n_samp < k) chk("sample_wait_expired", n_samp, k);
    endtask

    task automatic load(input int a, input int b);
        samp0.push_back(a);
        samp1.push_back(b);
    endtask

    function automatic int floor_div4(input int s);
        return (s - (((s % 4) + 4) % 4)) / 4;
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; end_conv = 1'b0; out_ready = 1'b1;
        clear_flags = 1'b0; ch0_in = '0; ch1_in = '0; ready0 = 1'b1;
        sum0 = 0; sum1 = 0; scnt = 0; mode = 0; n_samp = 0; conv_count = 0;
        suppress = 1'b0;

        fork
            // ADC reader model: answers each conv after 34 clocks (or late / never)
            forever begin
                @(posedge clk); #1;
                if (conv && !reset) begin
                    m = mode;
                    if (m != 0) begin sum0 = 0; sum1 = 0; scnt = 0; end
                    if (m != 1) begin
                        dly = (m == 2) ? 80 : 34;
                        repeat (dly) @(posedge clk);
                        #1;
                        if (suppress) begin
                            sum0 = 0; sum1 = 0; scnt = 0;
                        end else begin
                            c0 = (samp0.size() > 0) ? samp0.pop_front() : 0;
                            c1 = (samp1.size() > 0) ? samp1.pop_front() : 0;
                            ch0_in = DW'(c0);
                            ch1_in = DW'(c1);
                            end_conv = 1'b1;
                            @(posedge clk); #1;
                            end_conv = 1'b0;
                            if (m == 0) begin
                                q0a.push_back(c0);
                                q0b.push_back(c1);
                                sum0 += c0; sum1 += c1; scnt++;
                                if (scnt == 4) begin
                                    r0 = floor_div4(sum0);
                                    r1 = floor_div4(sum1);
                                    if (!(q2a.size() > 0 && !out_ready)) begin
                                        q2a.push_back(r0);
                                        q2b.push_back(r1);
                                    end
                                    sum0 = 0; sum1 = 0; scnt = 0;
                                end
                                n_samp++;
                            end
                        end
                    end
                end
            end
            // Output monitor: compare every handshake against the scoreboard
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (conv) conv_count++;
                    if (out_valid && out_ready) begin
                        if (q2a.size() == 0) chk("unexpected_avg_out", out_valid, 0);
                        else begin
                            chk("avg_ch0", $signed(out_ch0), q2a.pop_front());
                            chk("avg_ch1", $signed(out_ch1), q2b.pop_front());
                        end
                    end
                    if (out_valid0) begin
                        if (q0a.size() == 0) chk("unexpected_pt_out", out_valid0, 0);
                        else begin
                            chk("pt_ch0", $signed(out0_ch0), q0a.pop_front());
                            chk("pt_ch1", $signed(out0_ch1), q0b.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset state
        step(3);
        chk("rst_conv", conv, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ch0", $signed(out_ch0), 0);
        chk("rst_ch1", $signed(out_ch1), 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        reset = 1'b0;
        step(2);

        // Full-scale run; conv spacing
        for (int i = 0; i < 4; i++) load(8191, -8192);
        enable = 1'b1;
        wait_conv();
        wait_conv();
        chk("conv_period_a", cyc, 100);
        wait_conv();
        chk("conv_period_b", cyc, 100);
        wait_samples(4);
        step(5);

        // Floor averaging, nothing after only three samples
        load(10, -1); load(11, -1); load(12, -1); load(-1, -2);
        wait_samples(7);
        step(4);
        chk("no_early_valid", out_valid, 0);
        wait_samples(8);
        step(5);

        // Backpressure across two results
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(100, -100);
        for (int i = 0; i < 4; i++) load(4, 5);
        wait_samples(12);
        step(3);
        chk("bp_valid_first", out_valid, 1);
        chk("bp_no_overrun_yet", overrun, 0);
        wait_samples(16);
        step(3);
        chk("bp_overrun", overrun, 1);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_ch0", $signed(out_ch0), 100);
        chk("bp_hold_ch1", $signed(out_ch1), -100);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        chk("bp_overrun_cleared", overrun, 0);
        out_ready = 1'b1;
        step(3);
        chk("bp_drained", out_valid, 0);

        // Timeout discards a partial sum; late end_conv in WAIT is ignored
        load(1000, 1000); load(1000, 1000);
        wait_samples(18);
        mode = 1;
        wait_conv();
        step(63);
        chk("tmo_not_yet", timeout_err, 0);
        step(1);
        chk("tmo_at_64", timeout_err, 1);
        mode = 2;
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        chk("tmo_cleared", timeout_err, 0);
        step(35);
        chk("tmo_next_conv", conv, 1);
        step(85);
        chk("tmo_again", timeout_err, 1);
        chk("late_edge_no_out", out_valid, 0);
        mode = 0;
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        load(20, -3); load(30, -3); load(40, -3); load(50, -3);
        wait_samples(22);
        step(5);

        // Stop mid-BUSY: sample kept, no more conv, partial resumes later
        load(7, 1);
        wait_conv();
        step(5);
        enable = 1'b0;
        wait_samples(23);
        step(3);
        rec = conv_count;
        step(300);
        chk("stop_no_conv", conv_count - rec, 0);
        chk("stop_no_avg_out", out_valid, 0);
        load(9, 2); load(11, 3); load(13, 4);
        enable = 1'b1;
        wait_samples(26);
        step(5);

        // Asynchronous reset in the middle of a conversion
        load(5, 5);
        wait_conv();
        step(10);
        suppress = 1'b1;
        reset = 1'b1;
        #1;
        chk("arst_conv", conv, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ch0", $signed(out_ch0), 0);
        chk("arst_ch1", $signed(out_ch1), 0);
        chk("arst_pt_ch0", $signed(out0_ch0), 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_timeout", timeout_err, 0);
        step(40);
        reset = 1'b0;
        enable = 1'b0;
        step(10);

        chk("pt_no_overrun", overrun0, 0);
        chk("avg_queue_empty", q2a.size(), 0);
        chk("pt_queue_empty", q0a.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
